clause_state_tracker: RTL and testbench

//  Upstream feeder of unit_checker. Holds one clause's literals, consumes the solver's variable

---
 rtl/clause_state_tracker_pkg.sv | 15 +
 rtl/clause_state_tracker_lit_match.sv | 32 +++
 rtl/clause_state_tracker.sv | 181 ++++++++++++++++++
 tb/tb_clause_state_tracker.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clause_state_tracker_pkg.sv
// Shared types for the clause state tracker: FSM states and counter-width helper.
package clause_state_tracker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    // Bits needed to hold a count in 0..n.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/clause_state_tracker_lit_match.sv
// Combinational match of one assignment event against all stored literal slots,
// returning how many slots it makes true and how many it makes false.
module lit_match
    import clause_state_tracker_pkg::*;
#(
    parameter int VAR_W    = 3,
    parameter int MAX_LITS = 8,
    parameter int CNT_W    = cnt_width(MAX_LITS)
) (
    input  logic [MAX_LITS-1:0][VAR_W:0] slots,
    input  logic [MAX_LITS-1:0]          slot_vld,
    input  logic [VAR_W-1:0]             var_idx,
    input  logic                         val,
    output logic [CNT_W-1:0]             ntrue,
    output logic [CNT_W-1:0]             nfalse
);

    always_comb begin
        ntrue  = '0;
        nfalse = '0;
        for (int unsigned k = 0; k < MAX_LITS; k++) begin
            if (slot_vld[k] && (slots[k][VAR_W-1:0] == var_idx)) begin
                // slot literal is {neg, var}: true when the value differs from neg
                if (val != slots[k][VAR_W])
                    ntrue = ntrue + CNT_W'(1);
                else
                    nfalse = nfalse + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/clause_state_tracker.sv
// Holds one clause, tracks assign/undo events through a 2-stage pipeline and
// reports the false-literal count and partial-satisfaction flag with a strobe.
module clause_state_tracker
    import clause_state_tracker_pkg::*;
#(
    parameter  int SIZE     = 8,
    parameter  int VAR_NUM  = 8,
    parameter  int MAX_LITS = 8,
    localparam int VAR_W    = $clog2(VAR_NUM)
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             lit_valid,
    input  logic [VAR_W:0]   lit_data,
    input  logic             lit_last,
    output logic             lit_ready,
    input  logic             asg_valid,
    input  logic [VAR_W-1:0] asg_var,
    input  logic             asg_val,
    input  logic             asg_undo,
    output logic             asg_ready,
    output logic [SIZE-1:0]  counter,
    output logic [SIZE-1:0]  clause_size,
    output logic             part_sat,
    output logic             en_part_sat,
    output logic             overflow,
    output logic             asg_err
);

    localparam int LIT_W = VAR_W + 1;
    localparam int CNT_W = cnt_width(MAX_LITS);

    state_t state, state_nx;

    logic [MAX_LITS-1:0][LIT_W-1:0] slots;
    logic [MAX_LITS-1:0]            slot_vld;
    logic [VAR_NUM-1:0]             assigned;
    logic [VAR_NUM-1:0]             val_bm;

    logic             load_fire;
    logic             asg_fire;
    logic             asg_legal;
    logic             eff_val;
    logic [CNT_W-1:0] m_ntrue;
    logic [CNT_W-1:0] m_nfalse;

    logic             s1_valid;
    logic             s1_undo;
    logic [CNT_W-1:0] s1_ntrue;
    logic [CNT_W-1:0] s1_nfalse;

    logic [CNT_W-1:0] sat_cnt;
    logic [CNT_W-1:0] sat_cnt_nx;
    logic [SIZE-1:0]  counter_nx;

    assign lit_ready = (state == ST_IDLE) || (state == ST_LOAD);
    assign asg_ready = (state == ST_ACTIVE);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (lit_valid) state_nx = lit_last ? ST_ACTIVE : ST_LOAD;
            ST_LOAD:   if (lit_valid && lit_last) state_nx = ST_ACTIVE;
            ST_ACTIVE: state_nx = ST_ACTIVE;
            default:   state_nx = ST_IDLE;
        endcase
        if (clear) state_nx = ST_IDLE;
    end

    always_comb begin
        load_fire = lit_valid && lit_ready && !clear;
        asg_fire  = asg_valid && asg_ready && !clear;
        asg_legal = asg_undo ? assigned[asg_var] : !assigned[asg_var];
        // undo replays the stored value so its deltas exactly cancel the assign
        eff_val   = asg_undo ? val_bm[asg_var] : asg_val;
    end

    lit_match #(
        .VAR_W    (VAR_W),
        .MAX_LITS (MAX_LITS),
        .CNT_W    (CNT_W)
    ) u_lit_match (
        .slots    (slots),
        .slot_vld (slot_vld),
        .var_idx  (asg_var),
        .val      (eff_val),
        .ntrue    (m_ntrue),
        .nfalse   (m_nfalse)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            slots       <= '0;
            slot_vld    <= '0;
            clause_size <= '0;
            overflow    <= 1'b0;
        end else if (clear) begin
            slots       <= '0;
            slot_vld    <= '0;
            clause_size <= '0;
            overflow    <= 1'b0;
        end else if (load_fire) begin
            if (clause_size < SIZE'(MAX_LITS)) begin
                for (int unsigned k = 0; k < MAX_LITS; k++) begin
                    if (SIZE'(k) == clause_size) begin
                        slots[k]    <= lit_data;
                        slot_vld[k] <= 1'b1;
                    end
                end
                clause_size <= clause_size + 1'b1;
            end else begin
                overflow <= 1'b1;
            end
        end
    end

    // S1: legality check and bitmap update land on the same edge, so the next
    // cycle's event already sees them.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            assigned  <= '0;
            val_bm    <= '0;
            s1_valid  <= 1'b0;
            s1_undo   <= 1'b0;
            s1_ntrue  <= '0;
            s1_nfalse <= '0;
            asg_err   <= 1'b0;
        end else if (clear) begin
            assigned  <= '0;
            val_bm    <= '0;
            s1_valid  <= 1'b0;
            s1_undo   <= 1'b0;
            s1_ntrue  <= '0;
            s1_nfalse <= '0;
            asg_err   <= 1'b0;
        end else begin
            s1_valid  <= asg_fire && asg_legal;
            asg_err   <= asg_fire && !asg_legal;
            s1_undo   <= asg_undo;
            s1_ntrue  <= m_ntrue;
            s1_nfalse <= m_nfalse;
            if (asg_fire && asg_legal) begin
                assigned[asg_var] <= !asg_undo;
                if (!asg_undo) val_bm[asg_var] <= asg_val;
            end
        end
    end

    always_comb begin
        counter_nx = s1_undo ? (counter - SIZE'(s1_nfalse)) : (counter + SIZE'(s1_nfalse));
        sat_cnt_nx = s1_undo ? (sat_cnt - s1_ntrue) : (sat_cnt + s1_ntrue);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            counter     <= '0;
            sat_cnt     <= '0;
            part_sat    <= 1'b0;
            en_part_sat <= 1'b0;
        end else if (clear) begin
            counter     <= '0;
            sat_cnt     <= '0;
            part_sat    <= 1'b0;
            en_part_sat <= 1'b0;
        end else begin
            en_part_sat <= s1_valid;
            if (s1_valid) begin
                counter  <= counter_nx;
                sat_cnt  <= sat_cnt_nx;
                part_sat <= (sat_cnt_nx != '0);
            end
        end
    end

endmodule

// File: tb/tb_clause_state_tracker.sv
// Bench for clause_state_tracker: directed scenarios plus a randomized event
// stream, checked against a clause-level model that recounts literals each event.
module tb_clause_state_tracker;

    localparam int SIZE     = 8;
    localparam int VAR_NUM  = 8;
    localparam int MAX_LITS = 8;
    localparam int VAR_W    = 3;

    logic             clock = 1'b0;
    logic             rst_n;
    logic             clear;
    logic             lit_valid;
    logic [VAR_W:0]   lit_data;
    logic             lit_last;
    logic             lit_ready;
    logic             asg_valid;
    logic [VAR_W-1:0] asg_var;
    logic             asg_val;
    logic             asg_undo;
    logic             asg_ready;
    logic [SIZE-1:0]  counter;
    logic [SIZE-1:0]  clause_size;
    logic             part_sat;
    logic             en_part_sat;
    logic             overflow;
    logic             asg_err;

    always #5 clock = ~clock;

    clause_state_tracker #(
        .SIZE     (SIZE),
        .VAR_NUM  (VAR_NUM),
        .MAX_LITS (MAX_LITS)
    ) dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .clear       (clear),
        .lit_valid   (lit_valid),
        .lit_data    (lit_data),
        .lit_last    (lit_last),
        .lit_ready   (lit_ready),
        .asg_valid   (asg_valid),
        .asg_var     (asg_var),
        .asg_val     (asg_val),
        .asg_undo    (asg_undo),
        .asg_ready   (asg_ready),
        .counter     (counter),
        .clause_size (clause_size),
        .part_sat    (part_sat),
        .en_part_sat (en_part_sat),
        .overflow    (overflow),
        .asg_err     (asg_err)
    );

    int tests = 0;
    int fails = 0;

    // Model: the clause as a list of {neg,var} literals plus per-variable assignment.
    int unsigned q_lit[$];
    bit          m_asg[VAR_NUM];
    bit          m_val[VAR_NUM];

    function automatic int m_false();
        int n = 0;
        foreach (q_lit[i]) begin
            int v = int'(q_lit[i] % VAR_NUM);
            bit neg = (q_lit[i] / VAR_NUM) != 0;
            if (m_asg[v] && (m_val[v] == neg)) n++;
        end
        return n;
    endfunction

    function automatic bit m_sat();
        foreach (q_lit[i]) begin
            int v = int'(q_lit[i] % VAR_NUM);
            bit neg = (q_lit[i] / VAR_NUM) != 0;
            if (m_asg[v] && (m_val[v] != neg)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit m_apply(input int v, input bit val, input bit undo);
        if (undo) begin
            if (!m_asg[v]) return 1'b0;
            m_asg[v] = 1'b0;
        end else begin
            if (m_asg[v]) return 1'b0;
            m_asg[v] = 1'b1;
            m_val[v] = val;
        end
        return 1'b1;
    endfunction

    function automatic void m_reset();
        q_lit.delete();
        for (int i = 0; i < VAR_NUM; i++) begin
            m_asg[i] = 1'b0;
            m_val[i] = 1'b0;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        clear     = 1'b0;
        lit_valid = 1'b0;
        lit_data  = '0;
        lit_last  = 1'b0;
        asg_valid = 1'b0;
        asg_var   = '0;
        asg_val   = 1'b0;
        asg_undo  = 1'b0;
    endtask

    task automatic load_clause(input int unsigned lits[$]);
        foreach (lits[i]) begin
            lit_valid = 1'b1;
            lit_data  = (VAR_W+1)'(lits[i]);
            lit_last  = (i == lits.size() - 1);
            if (q_lit.size() < MAX_LITS) q_lit.push_back(lits[i]);
            step();
        end
        lit_valid = 1'b0;
        lit_last  = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        m_reset();
    endtask

    task automatic event_single(input string tag, input int v, input bit val, input bit undo);
        bit legal;
        legal     = m_apply(v, val, undo);
        asg_valid = 1'b1;
        asg_var   = VAR_W'(v);
        asg_val   = val;
        asg_undo  = undo;
        step();
        asg_valid = 1'b0;
        chk({tag, ".err"}, asg_err, !legal);
        chk({tag, ".s1_no_strobe"}, en_part_sat, 0);
        step();
        chk({tag, ".strobe"}, en_part_sat, legal);
        chk({tag, ".counter"}, counter, m_false());
        chk({tag, ".part_sat"}, part_sat, m_sat());
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, ".counter"}, counter, 0);
        chk({tag, ".size"}, clause_size, 0);
        chk({tag, ".part_sat"}, part_sat, 0);
        chk({tag, ".en"}, en_part_sat, 0);
        chk({tag, ".overflow"}, overflow, 0);
        chk({tag, ".asg_err"}, asg_err, 0);
        chk({tag, ".asg_ready"}, asg_ready, 0);
    endtask

    task automatic random_stream(input string tag, input int n);
        bit prev_legal = 1'b0;
        int prev_cnt   = 0;
        bit prev_sat   = 1'b0;
        for (int i = 0; i < n + 2; i++) begin
            bit cur_legal = 1'b0;
            bit cur_err   = 1'b0;
            if (i < n && $urandom_range(0, 3) != 0) begin
                int v    = int'($urandom_range(0, VAR_NUM - 1));
                bit val  = 1'($urandom_range(0, 1));
                bit undo = 1'($urandom_range(0, 1));
                cur_legal = m_apply(v, val, undo);
                cur_err   = !cur_legal;
                asg_valid = 1'b1;
                asg_var   = VAR_W'(v);
                asg_val   = val;
                asg_undo  = undo;
            end else begin
                asg_valid = 1'b0;
            end
            step();
            chk({tag, ".err"}, asg_err, cur_err);
            chk({tag, ".en"}, en_part_sat, prev_legal);
            if (prev_legal) begin
                chk({tag, ".counter"}, counter, prev_cnt);
                chk({tag, ".part_sat"}, part_sat, prev_sat);
            end
            prev_legal = cur_legal;
            prev_cnt   = m_false();
            prev_sat   = m_sat();
        end
        asg_valid = 1'b0;
    endtask

    initial begin
        int unsigned lits[$];
        drive_idle();
        m_reset();
        rst_n = 1'b0;
        #12;
        check_cleared("reset");
        chk("reset.lit_ready", lit_ready, 1);
        rst_n = 1'b1;
        step();

        // assign outside ACTIVE is ignored
        asg_valid = 1'b1; asg_var = 3'd0; asg_val = 1'b0;
        step();
        asg_valid = 1'b0;
        chk("idle_asg.err", asg_err, 0);
        step();
        chk("idle_asg.en", en_part_sat, 0);

        // clause (x0, ~x1, x2)
        lits = '{0, 8 + 1, 2};
        load_clause(lits);
        chk("t1.size", clause_size, 3);
        chk("t1.asg_ready", asg_ready, 1);
        chk("t1.lit_ready", lit_ready, 0);
        event_single("t1.x0", 0, 1'b0, 1'b0);
        event_single("t1.x1", 1, 1'b1, 1'b0);
        event_single("t2.x2", 2, 1'b1, 1'b0);
        event_single("t2.undo_x2", 2, 1'b0, 1'b1);
        event_single("t3.x0_again", 0, 1'b1, 1'b0);
        event_single("t3.undo_x5", 5, 1'b0, 1'b1);
        event_single("t3.absent_x6", 6, 1'b1, 1'b0);
        event_single("t5.undo_x0", 0, 1'b1, 1'b1);
        event_single("t5.undo_x1", 1, 1'b0, 1'b1);

        // back-to-back assign then undo of the same variable
        void'(m_apply(1, 1'b1, 1'b0));
        asg_valid = 1'b1; asg_var = 3'd1; asg_val = 1'b1; asg_undo = 1'b0;
        step();
        chk("t5.a.err", asg_err, 0);
        asg_undo = 1'b1; asg_val = 1'b0;
        step();
        asg_valid = 1'b0;
        chk("t5.b.err", asg_err, 0);
        chk("t5.a.en", en_part_sat, 1);
        chk("t5.a.counter", counter, 1);
        void'(m_apply(1, 1'b0, 1'b1));
        step();
        chk("t5.b.en", en_part_sat, 1);
        chk("t5.b.counter", counter, m_false());

        // in-flight event killed by clear
        void'(m_apply(2, 1'b0, 1'b0));
        asg_valid = 1'b1; asg_var = 3'd2; asg_val = 1'b0; asg_undo = 1'b0;
        step();
        asg_valid = 1'b0;
        do_clear();
        check_cleared("clr_inflight");
        chk("clr_inflight.lit_ready", lit_ready, 1);
        step();
        chk("clr_inflight.no_strobe", en_part_sat, 0);

        // clear wins over a same-cycle literal beat
        clear = 1'b1; lit_valid = 1'b1; lit_data = 4'd3; lit_last = 1'b1;
        step();
        drive_idle();
        chk("clr_lit.size", clause_size, 0);
        chk("clr_lit.lit_ready", lit_ready, 1);

        // overflow: nine literals offered
        lits = '{0, 1, 2, 3, 4, 5, 6, 7, 8 + 0};
        load_clause(lits);
        chk("t4.size", clause_size, 8);
        chk("t4.overflow", overflow, 1);
        chk("t4.asg_ready", asg_ready, 1);
        event_single("t4.x0_false", 0, 1'b0, 1'b0);
        do_clear();
        check_cleared("t4.clear");
        chk("t4.lit_ready", lit_ready, 1);

        // randomized clauses and event streams
        for (int r = 0; r < 4; r++) begin
            int n = int'($urandom_range(1, MAX_LITS));
            lits.delete();
            for (int i = 0; i < n; i++) lits.push_back($urandom_range(0, 2 * VAR_NUM - 1));
            load_clause(lits);
            chk("rnd.size", clause_size, n);
            random_stream("rnd", 80);
            do_clear();
        end

        // async reset mid-pipeline
        lits = '{8 + 3, 4};
        load_clause(lits);
        event_single("t6.x3", 3, 1'b1, 1'b0);
        asg_valid = 1'b1; asg_var = 3'd4; asg_val = 1'b0; asg_undo = 1'b0;
        step();
        asg_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_cleared("t6.reset");
        m_reset();
        #3 rst_n = 1'b1;
        step();
        chk("t6.no_strobe1", en_part_sat, 0);
        step();
        chk("t6.no_strobe2", en_part_sat, 0);
        chk("t6.counter", counter, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
